// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory responder and the core's decoder:
//   - access-size codes (RISC-V funct3 values for loads/stores)
//   - responder FSM state type
//   - latched request record
//   - helper that flags size codes with no defined access width
// -----------------------------------------------------------------------------
package mem_pkg;

   // Size codes, identical to the funct3 field the decoder forwards as memsize.
   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // One request as captured at acceptance.
   typedef struct packed {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   // 011, 110 and 111 have no access width.
   function automatic logic size_is_illegal(input logic [2:0] size);
      return !(size == MEM_B || size == MEM_H || size == MEM_W ||
               size == MEM_BU || size == MEM_HU);
   endfunction

endpackage : mem_pkg

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between the core's LSU (master) and the data-memory
// responder (slave).
//   req_valid  / req_ready   request handshake
//   req_we                   1 = store, 0 = load
//   req_size                 funct3 access size
//   req_addr                 byte address
//   req_wdata                store data (low bytes used for SB/SH)
//   resp_valid / resp_ready  response handshake
//   resp_rdata               extended load data, 0 for stores and errors
//   resp_err                 misaligned, out of range or illegal size
// -----------------------------------------------------------------------------
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface : dmem_responder_if

// File: rtl/dmem_responder_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational byte-lane steering for one access.
//   size        in   3   funct3 access size
//   addr_lo     in   2   byte offset within the word
//   rd_word     in   32  current contents of the addressed word
//   wdata       in   32  store data from the LSU
//   load_data   out  32  load result, sign/zero extended
//   store_word  out  32  rd_word with the stored lanes replaced
//   byte_en     out  4   lanes touched by a store of this size
//   misalign    out  1   H/HU on an odd address, W not word aligned
// Lanes are little-endian: lane i holds bits [8*i+7:8*i].
// -----------------------------------------------------------------------------
module mem_align
   import mem_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word,
   output logic [3:0]  byte_en,
   output logic        misalign
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] store_lanes;

   // Half selection uses only addr_lo[1]; an odd half address is flagged
   // as misaligned and its data is discarded upstream.
   assign byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
   assign half_sel = rd_word[{addr_lo[1], 4'b0000} +: 16];

   // NOTE: every output gets a default before the case so that no path
   // leaves a variable unassigned, which would infer a latch.
   always_comb begin
      load_data   = '0;
      store_lanes = '0;
      byte_en     = '0;
      misalign    = 1'b0;
      unique case (size)
         MEM_B: begin
            load_data   = {{24{byte_sel[7]}}, byte_sel};
            store_lanes = {4{wdata[7:0]}};
            byte_en     = 4'b0001 << addr_lo;
         end
         MEM_BU: begin
            load_data = {24'h0, byte_sel};
         end
         MEM_H: begin
            load_data   = {{16{half_sel[15]}}, half_sel};
            store_lanes = {2{wdata[15:0]}};
            byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign    = addr_lo[0];
         end
         MEM_HU: begin
            load_data = {16'h0, half_sel};
            misalign  = addr_lo[0];
         end
         MEM_W: begin
            load_data   = rd_word;
            store_lanes = wdata;
            byte_en     = 4'b1111;
            misalign    = |addr_lo;
         end
         default: ;
      endcase
   end

   // Replicated store data lands only in enabled lanes; the rest keep rd_word.
   always_comb begin
      store_word = rd_word;
      for (int i = 0; i < 4; i++) begin
         if (byte_en[i]) store_word[8*i +: 8] = store_lanes[8*i +: 8];
      end
   end

endmodule : mem_align

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the core's MEM stage. Accepts one load/store at a
// time, answers it LATENCY cycles after acceptance, and holds the answer until
// the LSU takes it.
//   clk     in   clock, rising edge
//   reset   in   synchronous, active-high
//   bus     slave modport of dmem_responder_if (request and response channels)
// Parameters:
//   DEPTH_WORDS  number of 32-bit words; byte addresses 0 .. 4*DEPTH_WORDS-1
//   LATENCY      cycles from acceptance to resp_valid, >= 1
// The access is resolved on the edge that enters RESP: the word is read, the
// error flags are evaluated, the store (if legal) is committed and the result
// is registered into resp_rdata/resp_err.
// -----------------------------------------------------------------------------
module dmem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic      clk,
   input  logic      reset,
   dmem_responder_if.slave bus
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   // WAIT runs LATENCY-1 cycles: counter loads LATENCY-2 and exits after 0.
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
   // One bit wider than the address so a full 4 GiB memory still compares.
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

   dmem_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   dmem_req_t         req_q, req_d;
   dmem_req_t         cur_req;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              accept;
   logic              enter_resp;

   logic [31:0]       mem [DEPTH_WORDS];
   logic [IDX_W-1:0]  word_idx;
   logic [31:0]       rd_word;
   logic [31:0]       load_data;
   logic [31:0]       store_word;
   logic [3:0]        byte_en;
   logic              misalign;
   logic              range_err;
   logic              size_err;
   logic              any_err;
   logic              mem_we;

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   assign accept = bus.req_valid && (state_q == IDLE);

   // With LATENCY==1 the access resolves on the accepting edge, before the
   // request has been latched, so the live bus fields are used while IDLE.
   always_comb begin
      if (state_q == IDLE) begin
         cur_req.we    = bus.req_we;
         cur_req.size  = bus.req_size;
         cur_req.addr  = bus.req_addr;
         cur_req.wdata = bus.req_wdata;
      end else begin
         cur_req = req_q;
      end
   end

   // ---------------------------------------------------------------- FSM ----
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      enter_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               req_d = cur_req;
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------ access resolve ----
   assign word_idx = cur_req.addr[IDX_W+1:2];
   assign rd_word  = mem[word_idx];

   mem_align u_align (
      .size       (cur_req.size),
      .addr_lo    (cur_req.addr[1:0]),
      .rd_word    (rd_word),
      .wdata      (cur_req.wdata),
      .load_data  (load_data),
      .store_word (store_word),
      .byte_en    (byte_en),
      .misalign   (misalign)
   );

   // Full-address compare: high address bits can never alias into range.
   assign range_err = {1'b0, cur_req.addr} >= ADDR_LIMIT;
   assign size_err  = size_is_illegal(cur_req.size) || (cur_req.we && cur_req.size[2]);
   assign any_err   = misalign || range_err || size_err;

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (enter_resp) begin
         err_d   = any_err;
         rdata_d = (any_err || cur_req.we) ? 32'h0 : load_data;
      end
   end

   // A reset coinciding with the WAIT->RESP edge abandons the store.
   assign mem_we = enter_resp && cur_req.we && !any_err && (|byte_en) && !reset;

   // ----------------------------------------------------------- registers ----
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // NOTE: the storage array has no reset; its contents survive reset and a
   // reset branch here would prevent mapping onto RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[word_idx] <= store_word;
   end

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed and randomized bench for dmem_responder (LATENCY=3, 1024 words).
// Expected results come from a byte-addressed reference memory updated with
// the load/store rules (access width, alignment, range, sign/zero extension).
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   import mem_pkg::*;

   localparam int DEPTH  = 1024;
   localparam int LAT    = 3;
   localparam int NBYTES = 4 * DEPTH;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference memory, one entry per byte.
   logic [7:0] mm [NBYTES];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Behavioural model of one access; updates mm for legal stores.
   task automatic model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err);
      int          nb;
      logic [31:0] v;
      err = 1'b0;
      rd  = 32'h0;
      nb  = 0;
      case (size)
         3'b000, 3'b100: nb = 1;
         3'b001, 3'b101: nb = 2;
         3'b010:         nb = 4;
         default:        err = 1'b1;
      endcase
      if (nb != 0 && (addr % 32'(nb)) != 0) err = 1'b1;
      if (addr >= 32'(NBYTES)) err = 1'b1;
      if (we && size[2]) err = 1'b1;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < nb; i++) mm[12'(addr + 32'(i))] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[12'(addr + 32'(i))];
            if (size == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (size == 3'b001) v = {{16{v[15]}}, v[15:0]};
            rd = v;
         end
      end
   endtask

   // One complete transaction. hold>0 keeps resp_ready low for that many
   // extra cycles once the response appears.
   task automatic xact(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold,
                       output logic [31:0] rd, output logic err);
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [31:0] first_rd;
      int          n;
      @(negedge clk);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      if (hold > 0) bus.resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 1;
      while (!bus.resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(LAT));
      check("req_ready_resp", 32'(bus.req_ready), 32'd0);
      first_rd = bus.resp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.resp_valid), 32'd1);
         check("hold_rdata", bus.resp_rdata, first_rd);
         check("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      rd  = bus.resp_rdata;
      err = bus.resp_err;
      model(we, size, addr, wdata, exp_rd, exp_err);
      check("rdata", rd, exp_rd);
      check("err", 32'(err), 32'(exp_err));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] rd;
      logic        er;
      logic [31:0] dummy_rd;
      logic        dummy_err;
      logic [31:0] addr;
      logic [2:0]  size;
      logic        we;
      int          r;
      int          n;

      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state.
      check("rst_req_ready",  32'(bus.req_ready),  32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata,      32'h0);
      check("rst_resp_err",   32'(bus.resp_err),   32'd0);

      // Word store and load.
      xact(1'b1, MEM_W, 32'h10, 32'h1234_5678, 0, rd, er);
      check("sw_0x10_rdata", rd, 32'h0);
      xact(1'b0, MEM_W, 32'h10, 32'h0, 0, rd, er);
      check("lw_0x10", rd, 32'h1234_5678);
      check("lw_0x10_err", 32'(er), 32'd0);

      // Byte lanes with sign/zero extension.
      xact(1'b1, MEM_B, 32'h11, 32'h0000_00AB, 0, rd, er);
      xact(1'b0, MEM_B, 32'h11, 32'h0, 0, rd, er);
      check("lb_0x11", rd, 32'hFFFF_FFAB);
      xact(1'b0, MEM_BU, 32'h11, 32'h0, 0, rd, er);
      check("lbu_0x11", rd, 32'h0000_00AB);
      xact(1'b0, MEM_W, 32'h10, 32'h0, 0, rd, er);
      check("lw_after_sb", rd, 32'h1234_AB78);

      // Halfword lanes.
      xact(1'b1, MEM_H, 32'h12, 32'h0000_8001, 0, rd, er);
      xact(1'b0, MEM_H, 32'h12, 32'h0, 0, rd, er);
      check("lh_0x12", rd, 32'hFFFF_8001);
      xact(1'b0, MEM_HU, 32'h12, 32'h0, 0, rd, er);
      check("lhu_0x12", rd, 32'h0000_8001);

      // Faults.
      xact(1'b0, MEM_W, 32'h6, 32'h0, 0, rd, er);
      check("lw_0x6_err", 32'(er), 32'd1);
      check("lw_0x6_rdata", rd, 32'h0);
      xact(1'b1, MEM_H, 32'h13, 32'h0000_FFFF, 0, rd, er);
      check("sh_0x13_err", 32'(er), 32'd1);
      xact(1'b0, MEM_W, 32'h10, 32'h0, 0, rd, er);
      check("lw_after_bad_sh", rd, 32'h8001_AB78);
      xact(1'b0, MEM_W, 32'(NBYTES), 32'h0, 0, rd, er);
      check("lw_limit_err", 32'(er), 32'd1);
      xact(1'b0, MEM_W, 32'h0001_0010, 32'h0, 0, rd, er);
      check("lw_alias_err", 32'(er), 32'd1);
      xact(1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er);
      check("size_011_err", 32'(er), 32'd1);
      xact(1'b1, MEM_BU, 32'h10, 32'hFFFF_FFFF, 0, rd, er);
      check("store_bu_err", 32'(er), 32'd1);
      xact(1'b0, MEM_W, 32'(NBYTES - 4), 32'h0, 0, rd, er);
      check("lw_last_word_err", 32'(er), 32'd0);

      // Response held for 5 cycles, then a request right behind it.
      xact(1'b0, MEM_W, 32'h10, 32'h0, 5, rd, er);
      check("lw_held", rd, 32'h8001_AB78);
      xact(1'b1, MEM_W, 32'h20, 32'hCAFE_F00D, 0, rd, er);

      // Reset while in WAIT: store abandoned, no response.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = MEM_W;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h0BAD_F00D;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("wait_rst_req_ready",  32'(bus.req_ready),  32'd1);
      check("wait_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("wait_rst_no_resp", 32'(bus.resp_valid), 32'd0);
      end
      xact(1'b0, MEM_W, 32'h20, 32'h0, 0, rd, er);
      check("lw_after_wait_rst", rd, 32'hCAFE_F00D);

      // Reset while in RESP: committed store stays, response dropped.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_size   = MEM_W;
      bus.req_addr   = 32'h24;
      bus.req_wdata  = 32'h5A5A_1234;
      bus.resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 1;
      while (!bus.resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("resp_rst_latency", 32'(n), 32'(LAT));
      model(1'b1, MEM_W, 32'h24, 32'h5A5A_1234, dummy_rd, dummy_err);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.resp_ready = 1'b1;
      check("resp_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      xact(1'b0, MEM_W, 32'h24, 32'h0, 0, rd, er);
      check("lw_after_resp_rst", rd, 32'h5A5A_1234);

      // Fill the low 256 bytes so random loads see defined data.
      for (int w = 0; w < 64; w++) begin
         xact(1'b1, MEM_W, 32'(w * 4), $urandom, 0, rd, er);
      end

      // Randomized traffic including misaligned, illegal and out-of-range.
      for (int k = 0; k < 200; k++) begin
         we   = 1'($urandom_range(0, 1));
         size = 3'($urandom_range(0, 7));
         r    = $urandom_range(0, 9);
         if (r == 0)      addr = 32'(NBYTES) + 32'($urandom_range(0, 64));
         else if (r == 1) addr = $urandom | 32'h8000_0000;
         else if (r == 2) addr = 32'(NBYTES - 4) + 32'($urandom_range(0, 3));
         else             addr = 32'($urandom_range(0, 255));
         xact(we, size, addr, $urandom, (r == 3) ? $urandom_range(1, 4) : 0, rd, er);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dmem_responder
